// File: rtl/data_bus_io_pkg.sv
// Register map and CTRL field layout shared by the I/O slave and its timer.
// Offsets are word offsets from BASE_ADDR; CTRL bit positions match the CPU driver.
// WR is the WR_RD level that marks a write cycle.
package data_bus_io_pkg;
   localparam logic [2:0]  OFF_GPIO_OUT   = 3'd0;
   localparam logic [2:0]  OFF_GPIO_IN    = 3'd1;
   localparam logic [2:0]  OFF_LOAD       = 3'd2;
   localparam logic [2:0]  OFF_CTRL       = 3'd3;
   localparam logic [2:0]  OFF_COUNT      = 3'd4;
   localparam logic [2:0]  OFF_STAT       = 3'd5;
   localparam logic [31:0] NUM_REGS       = 32'd6;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_AUTO      = 1;
   localparam int CTRL_IE        = 2;
   localparam int CTRL_PRESC_LSB = 3;

   localparam logic WR = 1'b1;
endpackage

// File: rtl/bus_timer.sv
// Prescaled down-counter with expiry flag for the data-bus I/O slave.
// Latency: COUNT/EXP update on the edge of a prescaler tick; LOAD write takes effect same edge.
// Backpressure: none; bus writes are always accepted and override timer activity.
module bus_timer #(
   parameter int PRESC_W = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               load_we,
   input  logic               ctrl_we,
   input  logic               stat_clr,
   input  logic [31:0]        wdata,
   input  logic [31:0]        load_val,
   input  logic               en,
   input  logic               auto_rl,
   input  logic [PRESC_W-1:0] presc,
   output logic [31:0]        count,
   output logic               exp,
   output logic               en_clr
);

   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [31:0]        count_q, count_d;
   logic               exp_q, exp_d;
   logic               tick;
   logic               expire;

   assign tick = en && (pcnt_q == presc);

   // Prescaler, counter and expiry next-state; a LOAD write discards a coincident tick.
   always_comb begin
      pcnt_d  = pcnt_q;
      count_d = count_q;
      expire  = 1'b0;
      if (!en || tick) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + PRESC_W'(1);
      end
      if (tick) begin
         if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
         end else if (count_q == 32'd1) begin
            expire  = 1'b1;
            count_d = auto_rl ? load_val : 32'd0;
         end else begin
            count_d = load_val;
         end
      end
      if (load_we) begin
         count_d = wdata;
         pcnt_d  = '0;
         expire  = 1'b0;
      end
      // A new expiry outranks a software clear on the same edge.
      if (expire) begin
         exp_d = 1'b1;
      end else if (stat_clr) begin
         exp_d = 1'b0;
      end else begin
         exp_d = exp_q;
      end
   end

   // One-shot mode stops the timer on expiry unless the CPU rewrites CTRL that edge.
   assign en_clr = expire && !auto_rl && !ctrl_we;
   assign count  = count_q;
   assign exp    = exp_q;

   // Timer state registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pcnt_q  <= '0;
         count_q <= '0;
         exp_q   <= 1'b0;
      end else begin
         pcnt_q  <= pcnt_d;
         count_q <= count_d;
         exp_q   <= exp_d;
      end
   end

endmodule

// File: rtl/data_bus_io_unit.sv
// Memory-mapped GPIO + timer slave on the CPU external data bus.
// Latency: writes land on the request edge; read data is registered, valid one CLK later.
// Backpressure: none; every access completes in one cycle with no wait states.
module data_bus_io_unit
   import data_bus_io_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
   parameter int          GPIO_W    = 16,
   parameter int          PRESC_W   = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       ADDR,
   input  logic [31:0]       Data_BUS_WRITE,
   input  logic              CS,
   input  logic              WR_RD,
   output logic [31:0]       Data_BUS_READ,
   output logic [GPIO_W-1:0] GPIO_OUT,
   input  logic [GPIO_W-1:0] GPIO_IN,
   output logic              IRQ
);

   logic [31:0]        offset;
   logic               hit, we, re;
   logic [GPIO_W-1:0]  gpio_out_q, sync1_q, sync2_q;
   logic [31:0]        load_q;
   logic               en_q, en_d, auto_q, ie_q;
   logic [PRESC_W-1:0] presc_q;
   logic               irq_q;
   logic [31:0]        rdata_q, rd_val;
   logic [31:0]        count;
   logic               exp_flag, en_clr;
   logic               load_we, ctrl_we, stat_clr;

   // Unsigned subtraction makes addresses below BASE_ADDR wrap high and miss.
   assign offset   = ADDR - BASE_ADDR;
   assign hit      = CS && (offset < NUM_REGS);
   assign we       = hit && (WR_RD == WR);
   assign re       = CS && (WR_RD != WR);
   assign load_we  = we && (offset[2:0] == OFF_LOAD);
   assign ctrl_we  = we && (offset[2:0] == OFF_CTRL);
   assign stat_clr = we && (offset[2:0] == OFF_STAT) && Data_BUS_WRITE[0];

   bus_timer #(.PRESC_W(PRESC_W)) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .load_we  (load_we),
      .ctrl_we  (ctrl_we),
      .stat_clr (stat_clr),
      .wdata    (Data_BUS_WRITE),
      .load_val (load_q),
      .en       (en_q),
      .auto_rl  (auto_q),
      .presc    (presc_q),
      .count    (count),
      .exp      (exp_flag),
      .en_clr   (en_clr)
   );

   // EN: a CPU CTRL write outranks the timer's one-shot stop.
   always_comb begin
      en_d = en_q;
      if (ctrl_we) begin
         en_d = Data_BUS_WRITE[CTRL_EN];
      end else if (en_clr) begin
         en_d = 1'b0;
      end
   end

   // Read mux, zero-extended to the bus width.
   always_comb begin
      rd_val = '0;
      case (offset[2:0])
         OFF_GPIO_OUT: rd_val[GPIO_W-1:0] = gpio_out_q;
         OFF_GPIO_IN:  rd_val[GPIO_W-1:0] = sync2_q;
         OFF_LOAD:     rd_val = load_q;
         OFF_CTRL: begin
            rd_val[CTRL_EN]                   = en_q;
            rd_val[CTRL_AUTO]                 = auto_q;
            rd_val[CTRL_IE]                   = ie_q;
            rd_val[CTRL_PRESC_LSB +: PRESC_W] = presc_q;
         end
         OFF_COUNT:    rd_val = count;
         OFF_STAT:     rd_val[0] = exp_flag;
         default:      rd_val = '0;
      endcase
   end

   // Register bank, input synchronizer, IRQ and registered read data.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         load_q     <= '0;
         en_q       <= 1'b0;
         auto_q     <= 1'b0;
         ie_q       <= 1'b0;
         presc_q    <= '0;
         irq_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         sync1_q <= GPIO_IN;
         sync2_q <= sync1_q;
         en_q    <= en_d;
         irq_q   <= exp_flag && ie_q;
         if (we && (offset[2:0] == OFF_GPIO_OUT)) begin
            gpio_out_q <= Data_BUS_WRITE[GPIO_W-1:0];
         end
         if (load_we) begin
            load_q <= Data_BUS_WRITE;
         end
         if (ctrl_we) begin
            auto_q  <= Data_BUS_WRITE[CTRL_AUTO];
            ie_q    <= Data_BUS_WRITE[CTRL_IE];
            presc_q <= Data_BUS_WRITE[CTRL_PRESC_LSB +: PRESC_W];
         end
         // A CS read miss returns zero; idle and write cycles hold the last read.
         if (re) begin
            rdata_q <= hit ? rd_val : 32'd0;
         end
      end
   end

   assign Data_BUS_READ = rdata_q;
   assign GPIO_OUT      = gpio_out_q;
   assign IRQ           = irq_q;

endmodule

// File: tb/tb_data_bus_io_unit.sv
// Self-checking bench for data_bus_io_unit: directed scenarios plus random bus traffic
// compared cycle by cycle against a transaction-level model of the register map.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_data_bus_io_unit;

   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] ADDR = '0;
   logic [31:0] Data_BUS_WRITE = '0;
   logic        CS = 1'b0;
   logic        WR_RD = 1'b0;
   logic [31:0] Data_BUS_READ;
   logic [15:0] GPIO_OUT;
   logic [15:0] GPIO_IN = '0;
   logic        IRQ;

   int nvec = 0;
   int nerr = 0;

   data_bus_io_unit #(.BASE_ADDR(BASE), .GPIO_W(16), .PRESC_W(8)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .ADDR           (ADDR),
      .Data_BUS_WRITE (Data_BUS_WRITE),
      .CS             (CS),
      .WR_RD          (WR_RD),
      .Data_BUS_READ  (Data_BUS_READ),
      .GPIO_OUT       (GPIO_OUT),
      .GPIO_IN        (GPIO_IN),
      .IRQ            (IRQ)
   );

   always #5 CLK = ~CLK;

   // Reference model state: architectural registers as the CPU sees them.
   logic [15:0] m_gpio;
   logic [15:0] m_pipe[$];
   logic [31:0] m_load, m_count, m_rd;
   logic        m_en, m_auto, m_ie, m_exp, m_irq;
   logic [7:0]  m_presc;
   int          m_pcnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h, want %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_gpio = '0; m_load = '0; m_count = '0; m_rd = '0;
      m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_irq = 0;
      m_presc = '0; m_pcnt = 0;
      m_pipe.delete();
      m_pipe.push_back(16'h0);
      m_pipe.push_back(16'h0);
   endtask

   // One bus clock of the model, all decisions taken on the pre-edge state.
   task automatic model_edge(input logic cs, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [15:0] gin);
      logic [31:0] off, regv;
      bit hit, we, tick, fire, stop;
      off = a - BASE;
      hit = cs && (off < 6);
      we  = hit && wr;
      case (off)
         0: regv = {16'h0, m_gpio};
         1: regv = {16'h0, m_pipe[0]};
         2: regv = m_load;
         3: regv = {21'h0, m_presc, m_ie, m_auto, m_en};
         4: regv = m_count;
         5: regv = {31'h0, m_exp};
         default: regv = 0;
      endcase
      if (cs && !wr) m_rd = hit ? regv : 32'h0;
      m_irq = m_exp && m_ie;
      tick = m_en && (m_pcnt == int'(m_presc));
      fire = 0;
      stop = 0;
      m_pcnt = (!m_en || tick) ? 0 : m_pcnt + 1;
      if (tick) begin
         if (m_count > 1) m_count = m_count - 1;
         else if (m_count == 1) begin
            fire = 1;
            m_count = m_auto ? m_load : 32'h0;
            stop = !m_auto;
         end else m_count = m_load;
      end
      if (we && off == 2) begin
         m_load = wd; m_count = wd; m_pcnt = 0; fire = 0; stop = 0;
      end
      if (fire) m_exp = 1;
      else if (we && off == 5 && wd[0]) m_exp = 0;
      if (we && off == 3) begin
         m_en = wd[0]; m_auto = wd[1]; m_ie = wd[2]; m_presc = wd[10:3];
      end else if (stop) m_en = 0;
      if (we && off == 0) m_gpio = wd[15:0];
      m_pipe.push_back(gin);
      void'(m_pipe.pop_front());
   endtask

   // Drive one bus cycle from a falling edge, step the model, compare, return at the next falling edge.
   task automatic cyc(input logic cs, input logic wr, input logic [31:0] a, input logic [31:0] wd);
      CS = cs; WR_RD = wr; ADDR = a; Data_BUS_WRITE = wd;
      @(posedge CLK);
      model_edge(cs, wr, a, wd, GPIO_IN);
      #1;
      chk("rdata", Data_BUS_READ, m_rd);
      chk("gpio_out", {16'h0, GPIO_OUT}, {16'h0, m_gpio});
      chk("irq", {31'h0, IRQ}, {31'h0, m_irq});
      @(negedge CLK);
   endtask

   task automatic wr_reg(input int off, input logic [31:0] wd);
      cyc(1'b1, 1'b1, BASE + off, wd);
   endtask

   task automatic rd_reg(input int off);
      cyc(1'b1, 1'b0, BASE + off, 32'h0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Asynchronous reset pulse starting between clock edges.
   task automatic pulse_reset(input string tag);
      #2;
      RST = 1'b0;
      #1;
      chk({tag, "_rd"}, Data_BUS_READ, 32'h0);
      chk({tag, "_gpio"}, {16'h0, GPIO_OUT}, 32'h0);
      chk({tag, "_irq"}, {31'h0, IRQ}, 32'h0);
      model_reset();
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      logic [31:0] a, wd, r;
      logic cs, wr;
      model_reset();
      repeat (2) @(negedge CLK);
      chk("reset_rd", Data_BUS_READ, 32'h0);
      chk("reset_gpio", {16'h0, GPIO_OUT}, 32'h0);
      chk("reset_irq", {31'h0, IRQ}, 32'h0);
      RST = 1'b1;
      @(negedge CLK);

      // GPIO_OUT write takes the low bits; read-back next cycle.
      wr_reg(0, 32'hFFFF_A5A5);
      chk("t1_gpio", {16'h0, GPIO_OUT}, 32'h0000_A5A5);
      rd_reg(0);
      chk("t1_rd", Data_BUS_READ, 32'h0000_A5A5);

      // GPIO_IN passes two synchronizer stages before it is readable.
      GPIO_IN = 16'h1234;
      rd_reg(1);
      chk("t2_early", Data_BUS_READ, 32'h0);
      rd_reg(1);
      rd_reg(1);
      chk("t2_sync", Data_BUS_READ, 32'h0000_1234);

      // One-shot countdown with PRESC=0.
      wr_reg(2, 32'd3);
      wr_reg(3, 32'h5);
      for (int i = 0; i < 4; i++) begin
         rd_reg(4);
         chk("t3_count", Data_BUS_READ, 32'(3 - i));
      end
      chk("t3_irq", {31'h0, IRQ}, 32'h1);
      rd_reg(5);
      chk("t3_exp", Data_BUS_READ, 32'h1);
      rd_reg(3);
      chk("t3_en_off", Data_BUS_READ, 32'h4);

      // Auto-reload with PRESC=3: expiry 8 cycles after CTRL write.
      wr_reg(5, 32'h1);
      wr_reg(2, 32'd2);
      wr_reg(3, 32'h1F);
      idle(7);
      rd_reg(5);
      chk("t4_not_yet", Data_BUS_READ, 32'h0);
      rd_reg(5);
      chk("t4_exp", Data_BUS_READ, 32'h1);
      rd_reg(4);
      chk("t4_reload", Data_BUS_READ, 32'd2);
      rd_reg(3);
      chk("t4_en_kept", Data_BUS_READ, 32'h1F);
      idle(4);
      // Clear on the exact expiry edge loses to the new expiry.
      wr_reg(5, 32'h1);
      rd_reg(5);
      chk("t5_set_wins", Data_BUS_READ, 32'h1);
      wr_reg(5, 32'h1);
      rd_reg(5);
      chk("t5_cleared", Data_BUS_READ, 32'h0);
      chk("t5_irq", {31'h0, IRQ}, 32'h0);

      // Misses and deselected writes.
      rd_reg(2);
      rd_reg(7);
      chk("t6_miss", Data_BUS_READ, 32'h0);
      rd_reg(2);
      cyc(1'b1, 1'b0, BASE - 1, 32'h0);
      chk("t6_below", Data_BUS_READ, 32'h0);
      rd_reg(2);
      cyc(1'b1, 1'b0, BASE + 32'h0001_0000, 32'h0);
      chk("t6_high_bits", Data_BUS_READ, 32'h0);
      cyc(1'b0, 1'b1, BASE, 32'h5555);
      chk("t6_cs_low", {16'h0, GPIO_OUT}, 32'h0000_A5A5);
      wr_reg(1, 32'hFFFF);
      wr_reg(4, 32'hFFFF);
      wr_reg(2, 32'd100);
      wr_reg(3, 32'h5);
      idle(3);
      rd_reg(2);
      chk("t6_pre_rst", Data_BUS_READ, 32'd100);
      pulse_reset("t6_rst");
      rd_reg(4);
      chk("t6_count_rst", Data_BUS_READ, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 5) GPIO_IN = 16'($urandom);
         if (i == 1500) pulse_reset("rand_rst");
         cs = ($urandom_range(0, 9) != 0);
         wr = ($urandom_range(0, 2) == 0);
         a  = ($urandom_range(0, 19) == 0) ? $urandom : BASE + $urandom_range(0, 7);
         wd = $urandom;
         if (a == BASE + 2 && $urandom_range(0, 7) != 0) wd = $urandom_range(0, 6);
         if (a == BASE + 3) wd[10:3] = 8'($urandom_range(0, 3));
         cyc(cs, wr, a, wd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
